// File: rtl/cmp_pkg.sv
// Shared types and encodings for the bit-serial magnitude comparator controller.
package cmp_pkg;

   // Controller states; the fourth code is unused and recovers to S_IDLE.
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   // One-hot result vector ordering is {gt, eq, lt}.
   localparam logic [2:0] RES_NONE = 3'b000;
   localparam logic [2:0] RES_GT   = 3'b100;
   localparam logic [2:0] RES_EQ   = 3'b010;
   localparam logic [2:0] RES_LT   = 3'b001;

endpackage

// File: rtl/serial_cmp_ctrl_if.sv
// Requester-side bus of the serial comparator: start/operands in, status/result out.
interface serial_cmp_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic             gt;
   logic             eq;
   logic             lt;

   // Requester drives the operation request and reads back the result.
   modport master (
      output start, a, b,
      input  busy, done, gt, eq, lt
   );

   // Comparator controller receives the request and reports the result.
   modport slave (
      input  start, a, b,
      output busy, done, gt, eq, lt
   );
endinterface

// File: rtl/cmp_shift_reg.sv
// Loadable left-shift register exposing its MSB; one per operand.
module cmp_shift_reg #(
   parameter int WIDTH = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             load,
   input  logic             shift,
   input  logic [WIDTH-1:0] d,
   output logic             msb
);

   logic [WIDTH-1:0] sr_q;
   logic [WIDTH-1:0] sr_d;

   // Next value: load wins over shift so a new operand always replaces the old one.
   always_comb begin
      sr_d = sr_q;
      if (load) begin
         sr_d = d;
      end else if (shift) begin
         sr_d = {sr_q[WIDTH-2:0], 1'b0};
      end
   end

   // Operand storage, cleared asynchronously.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         sr_q <= '0;
      end else begin
         sr_q <= sr_d;
      end
   end

   assign msb = sr_q[WIDTH-1];

endmodule

// File: rtl/serial_cmp_ctrl.sv
// Sequencer for a bit-serial magnitude comparator: walks both operands MSB-first
// and stops at the first differing bit, reporting a one-hot gt/eq/lt result.
module serial_cmp_ctrl
   import cmp_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input logic              CLK,
   input logic              RST,
   serial_cmp_ctrl_if.slave bus
);

   localparam int CNT_W = $clog2(WIDTH);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       res_q, res_d;
   logic             load;
   logic             shift;
   logic             sa_msb;
   logic             sb_msb;

   cmp_shift_reg #(.WIDTH(WIDTH)) u_sa (
      .CLK   (CLK),
      .RST   (RST),
      .load  (load),
      .shift (shift),
      .d     (bus.a),
      .msb   (sa_msb)
   );

   cmp_shift_reg #(.WIDTH(WIDTH)) u_sb (
      .CLK   (CLK),
      .RST   (RST),
      .load  (load),
      .shift (shift),
      .d     (bus.b),
      .msb   (sb_msb)
   );

   // State, bit counter and result registers; reset aborts any operation in flight.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         res_q   <= RES_NONE;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
      end
   end

   // Next-state logic: accept in IDLE, compare one bit per cycle in SHIFT, pulse DONE.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      load    = 1'b0;
      shift   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               load    = 1'b1;
               cnt_d   = CNT_W'(WIDTH - 1);
               res_d   = RES_NONE;
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (sa_msb && !sb_msb) begin
               res_d   = RES_GT;
               state_d = S_DONE;
            end else if (!sa_msb && sb_msb) begin
               res_d   = RES_LT;
               state_d = S_DONE;
            end else if (cnt_q == '0) begin
               // All bits matched; stopping here keeps the counter from wrapping.
               res_d   = RES_EQ;
               state_d = S_DONE;
            end else begin
               shift = 1'b1;
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Status is decoded from the state register only, so start has no path to it.
   assign bus.busy = (state_q == S_SHIFT) || (state_q == S_DONE);
   assign bus.done = (state_q == S_DONE);
   assign bus.gt   = res_q[2];
   assign bus.eq   = res_q[1];
   assign bus.lt   = res_q[0];

endmodule

// File: tb/tb_serial_cmp_ctrl.sv
// Self-checking bench for serial_cmp_ctrl (WIDTH=8).
module tb_serial_cmp_ctrl;

   localparam int WIDTH = 8;
   localparam logic [2:0] GT = 3'b100;
   localparam logic [2:0] EQ = 3'b010;
   localparam logic [2:0] LT = 3'b001;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   serial_cmp_ctrl_if #(.WIDTH(WIDTH)) bus ();

   serial_cmp_ctrl #(.WIDTH(WIDTH)) dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus)
   );

   logic [4:0] outs;
   logic [2:0] res;
   assign outs = {bus.busy, bus.done, bus.gt, bus.eq, bus.lt};
   assign res  = {bus.gt, bus.eq, bus.lt};

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [2:0] res;
      int         lat;
   } vec_t;

   vec_t vecs [10];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Reference: ordinary unsigned comparison.
   function automatic logic [2:0] res_of(input logic [7:0] va, input logic [7:0] vb);
      if (va > vb) return GT;
      if (va < vb) return LT;
      return EQ;
   endfunction

   // Reference: edges after accept until DONE = WIDTH - (index of highest differing bit).
   function automatic int lat_of(input logic [7:0] va, input logic [7:0] vb);
      logic [7:0] x;
      int l;
      x = va ^ vb;
      l = WIDTH;
      for (int i = 0; i < WIDTH; i++) begin
         if (x[i]) l = WIDTH - i;
      end
      return l;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One operation from IDLE: accept, wait for done, then check pulse width and hold.
   task automatic run_vec(input logic [7:0] va, input logic [7:0] vb,
                          input logic [2:0] eres, input int elat, input string name);
      int  cyc;
      int  busy_n;
      bit  held;
      bus.start = 1'b1;
      bus.a     = va;
      bus.b     = vb;
      tick();
      bus.start = 1'b0;
      bus.a     = 8'($urandom);
      bus.b     = 8'($urandom);
      cyc    = 1;
      busy_n = 0;
      while (!bus.done && cyc < 40) begin
         if (bus.busy) busy_n++;
         tick();
         cyc++;
      end
      if (bus.busy) busy_n++;
      $display("op %s a=%h b=%h res=%b cycles_to_done=%0d", name, va, vb, res, cyc);
      check({name, " latency"}, 32'(cyc - 1), 32'(elat));
      check({name, " result"}, 32'(res), 32'(eres));
      check({name, " busy cycles"}, 32'(busy_n), 32'(elat + 1));
      tick();
      check({name, " after done"}, 32'({bus.busy, bus.done}), 32'(0));
      held = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (res !== eres || bus.done !== 1'b0 || bus.busy !== 1'b0) held = 1'b0;
      end
      check({name, " result held"}, 32'(held), 32'(1));
   endtask

   initial begin
      int done_n;
      int done_cyc;
      int cyc;
      bit m_active;
      bit m_done;
      int m_rem;
      logic [2:0] m_res;
      logic [2:0] m_pend;
      logic       st;
      logic [7:0] va;
      logic [7:0] vb;
      logic [7:0] one;
      bit ok;

      vecs[0] = '{8'hA5, 8'hA5, EQ, 8};
      vecs[1] = '{8'h80, 8'h7F, GT, 1};
      vecs[2] = '{8'h12, 8'h13, LT, 8};
      vecs[3] = '{8'hFF, 8'h00, GT, 1};
      vecs[4] = '{8'h00, 8'hFF, LT, 1};
      vecs[5] = '{8'h00, 8'h00, EQ, 8};
      vecs[6] = '{8'h40, 8'h3F, GT, 2};
      vecs[7] = '{8'hFE, 8'hFF, LT, 8};
      vecs[8] = '{8'h0F, 8'h07, GT, 5};
      vecs[9] = '{8'h5A, 8'h5C, LT, 6};

      bus.start = 1'b0;
      bus.a     = 8'h00;
      bus.b     = 8'h00;

      // Asynchronous reset asserted mid-clock: outputs clear before any edge.
      #2 rst = 1'b1;
      #1;
      check("reset immediate", 32'(outs), 32'(0));
      tick();
      tick();
      rst = 1'b0;
      tick();
      check("idle after reset", 32'(outs), 32'(0));

      // Table of single operations.
      for (int v = 0; v < 10; v++) begin
         run_vec(vecs[v].a, vecs[v].b, vecs[v].res, vecs[v].lat, $sformatf("vec%0d", v));
      end

      // Start re-asserted with new operands during SHIFT is ignored.
      bus.start = 1'b1;
      bus.a     = 8'h01;
      bus.b     = 8'h02;
      tick();
      cyc      = 1;
      done_n   = 0;
      done_cyc = 0;
      for (int i = 0; i < 15; i++) begin
         bus.start = (cyc >= 2 && cyc <= 4);
         bus.a     = 8'hFF;
         bus.b     = 8'h00;
         if (bus.done) begin
            done_n++;
            done_cyc = cyc;
         end
         tick();
         cyc++;
      end
      bus.start = 1'b0;
      $display("op busy-start a=01 b=02 res=%b done_pulses=%0d", res, done_n);
      check("busy-start done pulses", 32'(done_n), 32'(1));
      check("busy-start done cycle", 32'(done_cyc), 32'(8));
      check("busy-start result", 32'(res), 32'(LT));

      // Start held continuously: back-to-back operations with one IDLE gap.
      bus.start = 1'b1;
      bus.a     = 8'h80;
      bus.b     = 8'h7F;
      done_n    = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (bus.done) done_n++;
      end
      bus.start = 1'b0;
      $display("op held-start a=80 b=7F res=%b done_pulses=%0d", res, done_n);
      check("held-start done pulses", 32'(done_n), 32'(4));
      tick();
      tick();
      check("held-start idle", 32'(outs), 32'({2'b00, GT}));

      // Reset in the 4th SHIFT cycle aborts with no done and cleared results.
      bus.start = 1'b1;
      bus.a     = 8'h55;
      bus.b     = 8'h55;
      tick();
      bus.start = 1'b0;
      tick();
      tick();
      tick();
      #3 rst = 1'b1;
      #1;
      check("abort outputs", 32'(outs), 32'(0));
      tick();
      rst = 1'b0;
      ok = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (outs !== 5'b0) ok = 1'b0;
      end
      $display("op abort a=55 b=55 quiet_after_reset=%0d", ok);
      check("abort no done", 32'(ok), 32'(1));
      run_vec(8'h03, 8'h01, GT, 7, "post-abort");

      // Random traffic against a latency/result reference model.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      m_active = 1'b0;
      m_done   = 1'b0;
      m_rem    = 0;
      m_res    = 3'b000;
      m_pend   = 3'b000;
      one      = 8'h01;
      for (int n = 0; n < 400; n++) begin
         st = ($urandom_range(0, 2) == 0);
         va = 8'($urandom);
         case ($urandom_range(0, 3))
            0:       vb = va;
            1:       vb = va ^ (one << $urandom_range(0, 7));
            default: vb = 8'($urandom);
         endcase
         bus.start = st;
         bus.a     = va;
         bus.b     = vb;
         @(posedge clk);
         if (m_done) begin
            m_done   = 1'b0;
            m_active = 1'b0;
         end else if (m_active) begin
            m_rem--;
            if (m_rem == 0) begin
               m_done = 1'b1;
               m_res  = m_pend;
            end
         end else if (st) begin
            m_active = 1'b1;
            m_rem    = lat_of(va, vb);
            m_res    = 3'b000;
            m_pend   = res_of(va, vb);
            $display("rand op a=%h b=%h exp=%b lat=%0d", va, vb, m_pend, m_rem);
         end
         #1;
         check("rand outputs", 32'(outs), 32'({m_active, m_done, m_res}));
      end
      bus.start = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
